imem_prog_loader: RTL

- Writer side of the instruction-memory debug load port: receives a framed byte stream from the host link and drives dbg_sig/dbg_addr/dbg_instr into instr_mem.
- Holds the core in reset while a program is loading.
- Sits between the debug link (UART/JTAG byte deserialiser) and the frontend stage's instruction memory.
- Frame format: SYNC byte, 4-byte word count (little-endian), N×4 data bytes (little-endian words), 1 XOR checksum byte.

---
 rtl/imem_prog_loader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_prog_loader.sv
// imem_prog_loader
// Writer side of the instruction-memory debug load port. Parses a framed
// byte stream (SYNC, 4-byte LE word count, LE data words, XOR checksum),
// writes each assembled word into instr_mem and holds the core while loading.
module imem_prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        dbg_sig,
    output logic        dbg_we,
    output logic [31:0] dbg_addr,
    output logic [31:0] dbg_instr,
    output logic        core_hold,
    output logic        done,
    output logic        err,
    output logic [31:0] words_loaded
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        DONE,
        ERR
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byteCnt_q, byteCnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [31:0]       words_q, words_d;

    logic              accept;
    logic [31:0]       assembled;
    logic              tmoExpired;
    logic              lastWrite;

    // Handshake and helper terms derived from the current state
    always_comb begin
        in_ready   = (state_q == IDLE) || (state_q == LEN) ||
                     (state_q == DATA) || (state_q == CHK);
        accept     = in_valid && in_ready;
        assembled  = {in_data, shift_q[31:8]};
        tmoExpired = (tmo_q == TMO_LAST);
        lastWrite  = we_q && ((words_q + 32'd1) == len_q);
    end

    // Next-state logic: frame parsing, word assembly, checksum and timeout
    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        shift_d   = shift_q;
        len_d     = len_q;
        chk_d     = chk_q;
        tmo_d     = tmo_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        instr_d   = instr_q;
        err_d     = err_q;
        words_d   = we_q ? (words_q + 32'd1) : words_q;

        case (state_q)
            IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d   = LEN;
                    byteCnt_d = 2'd0;
                    shift_d   = 32'd0;
                    len_d     = 32'd0;
                    chk_d     = 8'd0;
                    tmo_d     = '0;
                    err_d     = 1'b0;
                    words_d   = 32'd0;
                end
            end

            LEN: begin
                if (accept) begin
                    tmo_d     = '0;
                    shift_d   = assembled;
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        len_d = assembled;
                        if (assembled > MAX_WORDS) begin
                            state_d = ERR;
                        end else if (assembled == 32'd0) begin
                            state_d = CHK;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end else if (tmoExpired) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            DATA: begin
                if (lastWrite) begin
                    // A byte arriving during the final write cycle is already the checksum
                    if (accept) begin
                        tmo_d   = '0;
                        state_d = (in_data == chk_q) ? DONE : ERR;
                    end else begin
                        tmo_d   = tmo_q + 1'b1;
                        state_d = CHK;
                    end
                end else if (accept) begin
                    tmo_d     = '0;
                    chk_d     = chk_q ^ in_data;
                    shift_d   = assembled;
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q;
                        instr_d = assembled;
                    end
                end else if (tmoExpired) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            CHK: begin
                if (accept) begin
                    tmo_d   = '0;
                    state_d = (in_data == chk_q) ? DONE : ERR;
                end else if (tmoExpired) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ERR) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any frame in progress
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            byteCnt_q <= 2'd0;
            shift_q   <= 32'd0;
            len_q     <= 32'd0;
            chk_q     <= 8'd0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            instr_q   <= 32'd0;
            err_q     <= 1'b0;
            words_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            words_q   <= words_d;
        end
    end

    // Output mapping; the core is held for the entire frame including its last cycle
    always_comb begin
        dbg_sig      = (state_q == LEN) || (state_q == DATA) || (state_q == CHK) ||
                       (state_q == DONE) || (state_q == ERR);
        core_hold    = dbg_sig;
        done         = (state_q == DONE);
        err          = err_q;
        dbg_we       = we_q;
        dbg_addr     = addr_q;
        dbg_instr    = instr_q;
        words_loaded = words_q;
    end

endmodule
